// File: rtl/rv_pkg.sv
// Shared constants and helpers for the RV fetch path.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// Prefetch queue: slots allocated at request, filled at response,
// popped in order at the head.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    output logic            head_filled,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_data,
    output logic            full,
    output logic [PW:0]     outstanding
);

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW:0]      req_ptr;
    logic [PW:0]      rsp_ptr;
    logic [PW:0]      head_ptr;
    logic [PW:0]      allocated;
    logic             fill_ok;

    // Extra pointer bit distinguishes full from empty.
    assign allocated   = req_ptr - head_ptr;
    assign outstanding = req_ptr - rsp_ptr;
    assign full        = allocated == (PW+1)'(DEPTH);
    assign fill_ok     = fill && (outstanding != '0);

    assign head_filled = filled_q[head_ptr[PW-1:0]];
    assign head_pc     = pc_q[head_ptr[PW-1:0]];
    assign head_data   = data_q[head_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            req_ptr  <= '0;
            rsp_ptr  <= '0;
            head_ptr <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) begin
                filled_q[req_ptr[PW-1:0]] <= 1'b0;
                req_ptr <= req_ptr + 1'b1;
            end
            if (fill_ok) begin
                filled_q[rsp_ptr[PW-1:0]] <= 1'b1;
                rsp_ptr <= rsp_ptr + 1'b1;
            end
            if (pop) begin
                filled_q[head_ptr[PW-1:0]] <= 1'b0;
                head_ptr <= head_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) pc_q[req_ptr[PW-1:0]] <= alloc_pc;
        if (fill_ok) data_q[rsp_ptr[PW-1:0]] <= fill_data;
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order
// prefetch queue, redirect flush with wrong-path response dropping.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misalign_err
);

    localparam int PW = clog2(DEPTH);
    localparam int DW = 16;

    logic [XLEN-1:0] fetch_pc;
    logic [DW-1:0]   drop_cnt;
    logic [DW-1:0]   drop_nxt;
    logic [DW-1:0]   drop_sum;
    logic            full;
    logic            head_filled;
    logic [PW:0]     outstanding;
    logic            req_hs;
    logic            keep;
    logic            pop;

    assign imem_req_valid = !reset && !redirect_valid && !full;
    assign imem_addr      = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // Only new-path responses reach the queue.
    assign keep = imem_rsp_valid && !redirect_valid
                  && (drop_cnt == '0) && (outstanding != '0);

    assign inst_valid = head_filled && !redirect_valid && !reset;
    assign pop        = inst_valid && inst_ready;
    assign inst_pc4   = inst_pc + XLEN'(INST_BYTES);

    always_comb begin
        drop_nxt = drop_cnt;
        drop_sum = drop_cnt + DW'(outstanding);
        if (redirect_valid) begin
            if (imem_rsp_valid && (drop_sum != '0)) begin
                drop_nxt = drop_sum - 1'b1;
            end else begin
                drop_nxt = drop_sum;
            end
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            drop_cnt     <= '0;
            misalign_err <= 1'b0;
        end else begin
            drop_cnt <= drop_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (req_hs) begin
                fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
            end
        end
    end

    rv_fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .alloc       (req_hs),
        .alloc_pc    (fetch_pc),
        .fill        (keep),
        .fill_data   (imem_rsp_data),
        .pop         (pop),
        .head_filled (head_filled),
        .head_pc     (inst_pc),
        .head_data   (inst),
        .full        (full),
        .outstanding (outstanding)
    );

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Self-checking bench for rv_fetch_unit: latency-modelled memory,
// in-order scoreboard, table of redirect vectors, wrap instance.
module tb_rv_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct {
        int          lat;
        int          pre;
        int          rdy;
        logic [31:0] target;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misalign_err;

    logic        w_req_valid;
    logic        w_req_ready = 1'b1;
    logic [31:0] w_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = '0;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b1;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic [31:0] w_inst_pc4;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = '0;
    logic        w_mis;

    always #5 clk = ~clk;

    rv_fetch_unit #(.XLEN(32), .DEPTH(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    rv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (w_req_ready),
        .imem_addr      (w_addr),
        .imem_rsp_valid (w_rsp_valid),
        .imem_rsp_data  (w_rsp_data),
        .inst_valid     (w_inst_valid),
        .inst_ready     (w_inst_ready),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc),
        .inst_pc4       (w_inst_pc4),
        .redirect_valid (w_redir),
        .redirect_pc    (w_redir_pc),
        .misalign_err   (w_mis)
    );

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rdy_pct = 100;
    int          hs_cnt = 0;
    int          pop_cnt = 0;
    exp_t        sb[$];
    exp_t        wsb[$];
    mreq_t       mq[$];
    logic [31:0] exp_pc = '0;
    logic [31:0] w_exp_pc = WRAP_PC;
    logic [31:0] first_pc = '0;
    bit          first_pend = 1'b0;
    bit          iv_s = 1'b0;
    bit          wrap_seen = 1'b0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic step();
        bit          rs;
        bit          hs;
        bit          pp;
        bit          whs;
        logic [31:0] a;
        logic [31:0] wa;
        exp_t        e;
        mreq_t       m;
        @(negedge clk);
        rs   = reset;
        hs   = imem_req_valid && imem_req_ready;
        a    = imem_addr;
        pp   = inst_valid && inst_ready;
        iv_s = inst_valid;
        whs  = w_req_valid && w_req_ready;
        wa   = w_addr;
        if (rs) begin
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_inst_valid", inst_valid, 1'b0);
        end else begin
            if (redirect_valid) begin
                chk1("redir_req_valid", imem_req_valid, 1'b0);
                chk1("redir_inst_valid", inst_valid, 1'b0);
                sb.delete();
                exp_pc = redirect_pc & ~32'h3;
                first_pend = 1'b1;
            end else begin
                if (hs) begin
                    chk("req_addr", a, exp_pc);
                    sb.push_back('{exp_pc, mem_f(exp_pc)});
                    exp_pc += 32'd4;
                    hs_cnt++;
                end
                if (pp) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL pop_empty: got pc %h expected no pop", inst_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("inst_pc", inst_pc, e.pc);
                        chk("inst", inst, e.data);
                        chk("inst_pc4", inst_pc4, e.pc + 32'd4);
                    end
                    if (first_pend) first_pc = inst_pc;
                    first_pend = 1'b0;
                    pop_cnt++;
                end
            end
            if (whs) begin
                chk("wrap_req_addr", wa, w_exp_pc);
                wsb.push_back('{w_exp_pc, mem_f(w_exp_pc)});
                w_exp_pc += 32'd4;
            end
            if (w_inst_valid && w_inst_ready) begin
                if (wsb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL wrap_pop_empty: got pc %h expected no pop", w_inst_pc);
                end else begin
                    e = wsb.pop_front();
                    chk("wrap_inst_pc", w_inst_pc, e.pc);
                    chk("wrap_inst", w_inst, e.data);
                    chk("wrap_inst_pc4", w_inst_pc4, e.pc + 32'd4);
                    if (e.pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            mq.delete();
            sb.delete();
            wsb.delete();
            exp_pc = '0;
            w_exp_pc = WRAP_PC;
            imem_rsp_valid = 1'b0;
            w_rsp_valid = 1'b0;
        end else begin
            if (hs) mq.push_back('{a, cyc + lat});
            if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
                m = mq.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_f(m.addr);
            end else begin
                imem_rsp_valid = 1'b0;
            end
            w_rsp_valid = whs;
            w_rsp_data = mem_f(wa);
        end
        imem_req_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk1("rst_misalign", misalign_err, 1'b0);
        chk("rst_fetch_addr", imem_addr, 32'h0);
        hs_cnt = 0;
        pop_cnt = 0;
        first_pend = 1'b0;
    endtask

    task automatic run_pops(input int n, input int budget);
        int p0;
        int t;
        p0 = pop_cnt;
        t = 0;
        while (pop_cnt - p0 < n && t < budget) begin
            step();
            t++;
        end
        if (pop_cnt - p0 < n) begin
            nvec++;
            nerr++;
            $display("FAIL pop_timeout: got %0d pops expected %0d", pop_cnt - p0, n);
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc = t;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        vec_t vt[5];
        int   first_v;
        vt[0] = '{3, 5, 100, 32'h0000_0100, 1'b0};
        vt[1] = '{1, 6, 100, 32'h0000_0040, 1'b0};
        vt[2] = '{2, 3, 100, 32'h0000_0203, 1'b1};
        vt[3] = '{3, 1, 100, 32'h0000_0080, 1'b0};
        vt[4] = '{4, 8, 70,  32'h0000_1000, 1'b0};

        // reset release, L=1, streaming
        lat = 1;
        do_reset();
        first_v = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (iv_s && first_v == 0) first_v = k;
        end
        chk("first_valid_cycle", first_v, 3);
        chk("stream_pops", pop_cnt, 6);

        // stall with a full queue
        do_reset();
        inst_ready = 1'b0;
        repeat (10) step();
        chk("stall_req_count", hs_cnt, 4);
        chk1("stall_req_valid", imem_req_valid, 1'b0);
        chk1("stall_inst_valid", inst_valid, 1'b1);
        chk("stall_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        run_pops(4, 20);

        // redirect vectors
        foreach (vt[i]) begin
            lat = vt[i].lat;
            rdy_pct = vt[i].rdy;
            do_reset();
            repeat (vt[i].pre) step();
            redirect(vt[i].target);
            run_pops(6, 200);
            chk("vec_first_pc", first_pc, vt[i].target & ~32'h3);
            chk1("vec_misalign", misalign_err, vt[i].mis);
        end
        rdy_pct = 100;

        // back-to-back redirects
        lat = 3;
        do_reset();
        repeat (5) step();
        redirect(32'h300);
        repeat (2) step();
        redirect(32'h400);
        redirect(32'h500);
        run_pops(5, 100);
        chk("b2b_first_pc", first_pc, 32'h500);

        // sticky misalign survives an aligned redirect
        lat = 2;
        do_reset();
        repeat (3) step();
        redirect(32'h203);
        repeat (2) step();
        redirect(32'h300);
        run_pops(3, 100);
        chk("mis_after_aligned_pc", first_pc, 32'h300);
        chk1("mis_held", misalign_err, 1'b1);
        do_reset();
        chk1("mis_cleared", misalign_err, 1'b0);

        chk1("wrap_seen", wrap_seen, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Parametrised successor to the single-cycle fetch path (PC register, +4 adder, next-PC mux, combinational program memory).
- Decouples instruction fetch from decode through a prefetch queue.
- Issues pipelined requests to an instruction memory with variable latency and returns instructions in order, each with its PC and PC+4.
- Accepts branch/jump redirects and discards wrong-path fetches; sits between program memory and the decode/control stage.

Parameters:
- XLEN, 32, width of PC, address and instruction words.
- DEPTH, 4, queue slots (power of two, ≥2); bounds outstanding requests plus buffered instructions.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction; low means stall.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst.
- inst_pc4  out  XLEN  inst_pc + 4.
- redirect_valid  in  1  taken branch/jal/jalr this cycle.
- redirect_pc  in  XLEN  target address.
- misalign_err  out  1  sticky flag: some redirect_pc had bits[1:0] ≠ 0.

Behaviour:
- Reset, synchronous with reset high at the clk edge:
  - fetch_pc = RESET_PC.
  - All queue pointers and counters are 0, and the drop counter is 0.
  - misalign_err = 0.
  - imem_req_valid = 0 and inst_valid = 0 while reset is high.
  - The first request (addr RESET_PC) appears the cycle after reset deasserts.
- Queue slot layout: each slot holds {pc, data, filled}. Three pointers:
  - req_ptr: a slot is allocated at request handshake; pc is written there and filled is cleared.
  - rsp_ptr: a kept response writes data there and sets filled.
  - head_ptr: pops the slot.
- Credit: imem_req_valid = !reset && !redirect_valid && (allocated_slots < DEPTH).
  - allocated_slots counts requested-but-not-popped slots.
- On a request handshake: fetch_pc += 4, with wrap-around modulo 2^XLEN.
- Output:
  - inst_valid = head slot filled && !redirect_valid.
  - inst/inst_pc are from the head slot, combinationally.
  - inst_pc4 = inst_pc + 4, computed with the same modulo wrap.
  - A pop occurs on inst_valid && inst_ready.
- Latency: request accepted at cycle N, response at N+L → inst_valid at N+L+1 (registered into the queue).
  - Back-to-back throughput is 1 instruction/cycle when L < DEPTH.
- Redirect, in the cycle redirect_valid=1:
  - All pointers and allocated_slots are cleared.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued and no pop is counted.
  - drop_cnt = number of requests outstanding (accepted but not yet responded), minus 1 if imem_rsp_valid is also high that cycle.
  - The response arriving in the redirect cycle is discarded.
  - If redirect_pc[1:0] ≠ 0, misalign_err is set; it stays set until reset.
- Drop: while drop_cnt > 0, each imem_rsp_valid decrements drop_cnt and its data is discarded.
  - New-path requests may issue while drop_cnt > 0. The in-order response guarantee keeps old and new responses separated.
- Back-to-back redirects: each new redirect recomputes drop_cnt = existing drop_cnt + new-path outstanding, minus an arriving response.
  - The latest redirect_pc wins.
- Full queue: requests stop; inst_ready low holds the head stable (inst, inst_pc constant).
- Empty queue: inst_valid = 0.
- Reset mid-operation: same as reset from idle. Responses to requests issued before reset are not tracked; the memory is reset alongside.
- A response with no allocated outstanding slot is a protocol error and is ignored. Bench assertion: no rsp without an outstanding request.

Decomposition:
- rv_pkg holds: XLEN default, INST_BYTES=4, the RESET_PC default, and the pointer-width function clog2(DEPTH).
- Sub-module rv_fetch_queue holds the slot array with req/rsp/head pointers, filled bits, allocated count and flush.
- rv_fetch_unit keeps fetch_pc, the credit logic, drop_cnt and redirect handling.

Test Plan:
- Reset release, memory latency L=1, inst_ready=1 → requests 0x0,0x4,0x8… one per cycle; first inst_valid with inst_pc=0x0, inst_pc4=0x4 two cycles after reset deasserts.
- Stall: inst_ready=0 for 10 cycles with DEPTH=4, L=1 → exactly 4 requests accepted, then imem_req_valid=0; head stays inst_pc=0x0; on release, pcs 0x0..0xC pop in order.
- Redirect with 3 outstanding (L=3) to 0x100 → next request addr 0x100; the 3 old responses are dropped; next popped inst_pc=0x100, no 0x0C/0x10 seen.
- Redirect coincident with a response and a pop → that response is dropped, the pop is not counted, inst_valid=0 that cycle; next popped pc=target.
- redirect_pc=0x203 → fetch at 0x200, misalign_err=1 and held until reset.
- Wrap: RESET_PC=32'hFFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc4 for FFFF_FFFC = 0000_0000.
